// File: rtl/axi_rd_arbiter.sv
// Four-requester AXI read-channel arbiter in front of one shared read slave; AXI_RD_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
// Grant one cycle after request; one transaction in flight, address held until m_arready, data beats follow the owner's s_rready.
module axi_rd_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  anreset,
    input  logic [3:0]            s_arvalid,
    input  logic [4*ADDR_W-1:0]   s_araddr,
    output logic [3:0]            s_arready,
    output logic [3:0]            s_rvalid,
    input  logic [3:0]            s_rready,
    output logic [DATA_W-1:0]     s_rdata,
    output logic                  s_rlast,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    output logic [ADDR_W-1:0]     m_araddr,
    input  logic                  m_rvalid,
    input  logic                  m_rlast,
    input  logic [DATA_W-1:0]     m_rdata,
    output logic                  m_rready,
    output logic [3:0]            grant
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADDR = 2'd1;
    localparam logic [1:0] DATA = 2'd2;

    logic [1:0]        state;
    logic [1:0]        gnt_idx;
    logic [1:0]        pick_idx;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] req_addr [4];
    logic [3:0]        gnt_oh;

    for (genvar i = 0; i < 4; i++) begin : g_addr
        assign req_addr[i] = s_araddr[i*ADDR_W +: ADDR_W];
    end

`ifdef AXI_RD_ARB_FIXED_PRIO_EN
    always_comb begin
        pick_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (s_arvalid[i]) pick_idx = 2'(i);
        end
    end
`else
    logic [1:0] last_grant;

    // Scan downward so the closest requester after last_grant is written last and wins.
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
        logic [1:0] cand;
        rr_pick = last;
        for (int k = 4; k >= 1; k--) begin
            cand = last + 2'(k);
            if (req[cand]) rr_pick = cand;
        end
    endfunction

    always_comb begin
        pick_idx = rr_pick(s_arvalid, last_grant);
    end

    always_ff @(posedge clk or negedge anreset) begin
        if (!anreset) begin
            last_grant <= 2'd3;
        end else if (state == DATA && m_rvalid && m_rready && m_rlast) begin
            last_grant <= gnt_idx;
        end
    end
`endif

    always_ff @(posedge clk or negedge anreset) begin
        if (!anreset) begin
            state   <= IDLE;
            gnt_idx <= 2'd0;
            addr_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|s_arvalid) begin
                        gnt_idx <= pick_idx;
                        addr_q  <= req_addr[pick_idx];
                        state   <= ADDR;
                    end
                end
                ADDR: begin
                    if (m_arready) state <= DATA;
                end
                DATA: begin
                    if (m_rvalid && m_rready && m_rlast) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign gnt_oh    = 4'b0001 << gnt_idx;
    assign grant     = (state != IDLE) ? gnt_oh : 4'b0000;
    assign m_arvalid = (state == ADDR);
    assign m_araddr  = addr_q;
    assign s_arready = (state == ADDR && m_arready) ? gnt_oh : 4'b0000;
    assign s_rvalid  = (state == DATA && m_rvalid) ? gnt_oh : 4'b0000;
    assign m_rready  = (state == DATA) && s_rready[gnt_idx];
    // Data path is a pass-through, forced low only so every output reads 0 during reset.
    assign s_rdata   = anreset ? m_rdata : '0;
    assign s_rlast   = anreset & m_rlast;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: reset, single beat, rotation, address stall, gated burst, no pre-emption, mid-burst reset.
module tb_axi_rd_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            anreset;
    logic [3:0]      s_arvalid;
    logic [4*AW-1:0] s_araddr;
    logic [3:0]      s_arready;
    logic [3:0]      s_rvalid;
    logic [3:0]      s_rready;
    logic [DW-1:0]   s_rdata;
    logic            s_rlast;
    logic            m_arvalid;
    logic            m_arready;
    logic [AW-1:0]   m_araddr;
    logic            m_rvalid;
    logic            m_rlast;
    logic [DW-1:0]   m_rdata;
    logic            m_rready;
    logic [3:0]      grant;

    int checks = 0;
    int errors = 0;

    axi_rd_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .anreset   (anreset),
        .s_arvalid (s_arvalid),
        .s_araddr  (s_araddr),
        .s_arready (s_arready),
        .s_rvalid  (s_rvalid),
        .s_rready  (s_rready),
        .s_rdata   (s_rdata),
        .s_rlast   (s_rlast),
        .m_arvalid (m_arvalid),
        .m_arready (m_arready),
        .m_araddr  (m_araddr),
        .m_rvalid  (m_rvalid),
        .m_rlast   (m_rlast),
        .m_rdata   (m_rdata),
        .m_rready  (m_rready),
        .grant     (grant)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [1:0]  exp_idx;
        logic [5:0]  pat;
        logic        rr;
        int          xfers;

        anreset   = 1'b0;
        s_arvalid = 4'b0001;
        s_araddr  = '0;
        s_araddr[0*AW +: AW] = 32'h0000_0100;
        s_rready  = 4'b0000;
        m_arready = 1'b1;
        m_rvalid  = 1'b0;
        m_rlast   = 1'b0;
        m_rdata   = 32'h5555_AAAA;

        // Reset holds everything at zero even with a request pending
        tick(); tick(); #1;
        chk("rst_grant",   grant,     4'b0000);
        chk("rst_arvalid", m_arvalid, 1'b0);
        chk("rst_araddr",  m_araddr,  32'h0);
        chk("rst_arready", s_arready, 4'b0000);
        chk("rst_rready",  m_rready,  1'b0);
        chk("rst_rdata",   s_rdata,   32'h0);
        anreset = 1'b1;
        #1;
        chk("rel_grant", grant, 4'b0000);

        // Single-beat read from requester 0
        tick(); #1;
        chk("t1_grant",   grant,     4'b0001);
        chk("t1_arvalid", m_arvalid, 1'b1);
        chk("t1_araddr",  m_araddr,  32'h0000_0100);
        chk("t1_arready", s_arready, 4'b0001);
        s_arvalid = 4'b0000;
        tick();
        m_rvalid = 1'b1; m_rlast = 1'b1; m_rdata = 32'hA5A5_0001; s_rready = 4'b0001;
        #1;
        chk("t1_rvalid",   s_rvalid,  4'b0001);
        chk("t1_rready",   m_rready,  1'b1);
        chk("t1_rdata",    s_rdata,   32'hA5A5_0001);
        chk("t1_rlast",    s_rlast,   1'b1);
        chk("t1_arv_data", m_arvalid, 1'b0);
        tick();
        m_rvalid = 1'b0; m_rlast = 1'b0;
        #1;
        chk("t1_idle_grant",  grant,    4'b0000);
        chk("t1_idle_rvalid", s_rvalid, 4'b0000);

        // Fresh reset, then all four requesting: rotation 0,1,2,3
        anreset = 1'b0; #1; anreset = 1'b1;
        for (int i = 0; i < 4; i++) s_araddr[i*AW +: AW] = 32'h1000 + 32'(i * 16);
        s_arvalid = 4'b1111;
        s_rready  = 4'b1111;
        for (int t = 0; t < 4; t++) begin
`ifdef AXI_RD_ARB_FIXED_PRIO_EN
            exp_idx = 2'd0;
`else
            exp_idx = 2'(t);
`endif
            tick(); #1;
            chk("t2_grant",  grant,    4'b0001 << exp_idx);
            chk("t2_araddr", m_araddr, 32'h1000 + 32'(exp_idx) * 16);
            tick();
            m_rvalid = 1'b1; m_rlast = 1'b1;
            #1;
            chk("t2_rvalid", s_rvalid, 4'b0001 << exp_idx);
            tick();
            m_rvalid = 1'b0; m_rlast = 1'b0;
            #1;
            chk("t2_idle", grant, 4'b0000);
        end
        s_arvalid = 4'b0000;

        // Address stalled three cycles by the slave
        s_arvalid = 4'b0100;
        s_araddr[2*AW +: AW] = 32'hDEAD_BEE0;
        m_arready = 1'b0;
        tick();
        s_arvalid = 4'b0000;
        s_araddr[2*AW +: AW] = 32'h0;
        #1;
        chk("t3_grant",   grant,     4'b0100);
        chk("t3_arvalid", m_arvalid, 1'b1);
        chk("t3_araddr",  m_araddr,  32'hDEAD_BEE0);
        chk("t3_arready", s_arready, 4'b0000);
        for (int c = 0; c < 2; c++) begin
            tick(); #1;
            chk("t3_hold_arvalid", m_arvalid, 1'b1);
            chk("t3_hold_araddr",  m_araddr,  32'hDEAD_BEE0);
            chk("t3_hold_arready", s_arready, 4'b0000);
        end
        tick();
        m_arready = 1'b1;
        #1;
        chk("t3_acc_arvalid", m_arvalid, 1'b1);
        chk("t3_acc_araddr",  m_araddr,  32'hDEAD_BEE0);
        chk("t3_acc_arready", s_arready, 4'b0100);
        tick();
        m_arready = 1'b0;

        // Four-beat burst gated by the owner's ready 1,0,1,0,1,1; other readies held high
        pat   = 6'b110101;
        xfers = 0;
        for (int c = 0; c < 6; c++) begin
            rr       = pat[c];
            s_rready = rr ? 4'b0100 : 4'b1011;
            m_rvalid = 1'b1;
            m_rlast  = (c == 5);
            m_rdata  = 32'hB000_0000 + 32'(c);
            #1;
            chk("t4_rready", m_rready, rr);
            chk("t4_rvalid", s_rvalid, 4'b0100);
            if (m_rvalid && m_rready) xfers++;
            tick();
        end
        m_rvalid = 1'b0; m_rlast = 1'b0;
        #1;
        chk("t4_xfers", xfers, 4);
        chk("t4_idle",  grant, 4'b0000);

        // Requester 2 arrives during requester 1's data phase and must wait
        s_arvalid = 4'b0010;
        s_araddr[1*AW +: AW] = 32'h2222_0000;
        m_arready = 1'b1;
        tick();
        s_arvalid = 4'b0000;
        #1;
        chk("t5_grant_r1", grant, 4'b0010);
        tick();
        s_arvalid = 4'b0100;
        s_araddr[2*AW +: AW] = 32'h3333_0000;
        m_rvalid = 1'b1; m_rlast = 1'b0; s_rready = 4'b1111;
        #1;
        chk("t5_beat1_grant",  grant,    4'b0010);
        chk("t5_beat1_rvalid", s_rvalid, 4'b0010);
        tick();
        m_rlast = 1'b1;
        #1;
        chk("t5_beat2_grant", grant, 4'b0010);
        tick();
        m_rvalid = 1'b0; m_rlast = 1'b0;
        #1;
        chk("t5_idle", grant, 4'b0000);
        tick(); #1;
        chk("t5_grant_r2",  grant,    4'b0100);
        chk("t5_araddr_r2", m_araddr, 32'h3333_0000);

        // Reset in the middle of requester 2's burst, then a clean restart
        s_arvalid = 4'b0000;
        tick();
        m_rvalid = 1'b1; m_rlast = 1'b0; m_rdata = 32'hC0DE_0001;
        #1;
        chk("t6_pre_rready", m_rready, 1'b1);
        tick();
        anreset = 1'b0;
        #1;
        chk("t6_rst_grant",   grant,     4'b0000);
        chk("t6_rst_rready",  m_rready,  1'b0);
        chk("t6_rst_rvalid",  s_rvalid,  4'b0000);
        chk("t6_rst_arvalid", m_arvalid, 1'b0);
        chk("t6_rst_araddr",  m_araddr,  32'h0);
        chk("t6_rst_rdata",   s_rdata,   32'h0);
        tick(); #1;
        chk("t6_rst_hold_rvalid", s_rvalid, 4'b0000);
        m_rvalid  = 1'b0;
        s_arvalid = 4'b0001;
        s_araddr[0*AW +: AW] = 32'h0000_4440;
        anreset = 1'b1;
        #1;
        chk("t6_rel_grant", grant, 4'b0000);
        tick(); #1;
        chk("t6_grant",  grant,    4'b0001);
        chk("t6_araddr", m_araddr, 32'h0000_4440);
        s_arvalid = 4'b0000;
        tick();
        m_rvalid = 1'b1; m_rlast = 1'b1; s_rready = 4'b0001;
        #1;
        chk("t6_rvalid", s_rvalid, 4'b0001);
        tick();
        m_rvalid = 1'b0; m_rlast = 1'b0;
        #1;
        chk("t6_idle", grant, 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_rd_arbiter.md
AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

Interface
REQ-001 The block SHALL have parameters: ADDR_W, default 32, address width; DATA_W, default 32, read data width. The requester count SHALL be fixed at 4.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 anreset  input  1  reset, asynchronous, active-low.
REQ-004 s_arvalid  input  4  per-requester read-address valid; bit i belongs to requester i.
REQ-005 s_araddr  input  4*ADDR_W  per-requester address; requester i occupies bits [i*ADDR_W +: ADDR_W].
REQ-006 s_arready  output  4  per-requester address accept.
REQ-007 s_rvalid  output  4  per-requester read-data valid.
REQ-008 s_rready  input  4  per-requester read-data ready.
REQ-009 s_rdata  output  DATA_W  shared read data, a copy of m_rdata.
REQ-010 s_rlast  output  1  shared last-beat flag, a copy of m_rlast.
REQ-011 m_arvalid  output  1  address valid toward the shared read slave.
REQ-012 m_arready  input  1  address ready from the shared read slave.
REQ-013 m_araddr  output  ADDR_W  registered address.
REQ-014 m_rvalid, m_rlast  input  1 each  data valid and last beat from the slave.
REQ-015 m_rdata  input  DATA_W  read data from the slave.
REQ-016 m_rready  output  1  data ready toward the slave.
REQ-017 grant  output  4  one-hot owner of the slave, or 0 when idle.

Function
REQ-018 The block SHALL implement a 3-state FSM:
- IDLE: grant=0, m_arvalid=0, m_rready=0, all s_arready and s_rvalid 0.
- ADDR: address phase of the granted requester.
- DATA: read-data phase of the granted requester.
REQ-019 In IDLE with any s_arvalid bit high, the block SHALL:
- select one requester by round-robin, searching from (last_grant+1) mod 4 upward;
- register its index and its address;
- enter ADDR on the next edge.
REQ-020 Latency SHALL be exactly 1 cycle: s_arvalid sampled high at edge n gives m_arvalid high after edge n.
REQ-021 In ADDR, m_arvalid SHALL be 1 and m_araddr SHALL hold the registered address stable.
REQ-022 In ADDR, s_arready[g] SHALL equal m_arready, where g is the granted index; the other s_arready bits SHALL be 0.
REQ-023 In ADDR, m_arready=1 SHALL move the FSM to DATA; m_arvalid SHALL never drop before that handshake, even if s_arvalid[g] falls.
REQ-024 In DATA:
- s_rvalid[g] SHALL equal m_rvalid; the other s_rvalid bits SHALL be 0;
- m_rready SHALL equal s_rready[g];
- a beat SHALL transfer only when m_rvalid and m_rready are both 1.
REQ-025 A transferred beat with m_rlast=1 SHALL return the FSM to IDLE and set last_grant to g. Only one transaction SHALL be outstanding at a time.
REQ-026 A requester that holds s_arvalid high SHALL be granted within 4 transactions.
REQ-027 Requests from other requesters arriving during ADDR or DATA SHALL wait; they SHALL NOT pre-empt the current owner.
REQ-028 A single-beat read (m_rlast on the first beat) SHALL be legal. The minimum IDLE→IDLE sequence SHALL be 3 cycles: IDLE, ADDR, DATA.

Reset
REQ-029 While anreset=0, asynchronously, the FSM SHALL be IDLE and last_grant SHALL be 3, so requester 0 wins first.
REQ-030 While anreset=0, the registered address SHALL be 0 and all outputs SHALL be 0.
REQ-031 Reset asserted in ADDR or DATA SHALL abort the transaction immediately, with no further s_arready or s_rvalid pulses.
REQ-032 The first grant after reset deassertion SHALL occur no earlier than the first rising edge at which anreset=1.

Configuration
REQ-033 Macro AXI_RD_ARB_FIXED_PRIO_EN SHALL control the arbitration policy.
- Defined: fixed priority; requester 0 highest, 3 lowest; last_grant SHALL be ignored.
- Undefined: round-robin per REQ-019.
- All other behaviour SHALL be identical in both builds.

Verification
REQ-034 Reset, then s_arvalid=4'b0001, address 0x100, m_arready=1, a single beat with m_rlast -> grant=0001 one cycle after the request; m_araddr=0x100; s_rvalid[0] pulses once; back to IDLE.
REQ-035 s_arvalid=4'b1111 held through four 1-beat transactions -> grants in order 0001, 0010, 0100, 1000; with FIXED_PRIO_EN, grants 0001 four times.
REQ-036 m_arready held 0 for 3 cycles -> m_arvalid and m_araddr stay stable for 4 cycles; s_arready[g] is 1 only in the accept cycle.
REQ-037 A 4-beat burst with s_rready[g] toggling 1,0,1,0,1,1 -> exactly 4 transfers; no transfer on s_rready=0 cycles; other s_rvalid bits stay 0; IDLE after the 4th beat.
REQ-038 Requester 2 raises s_arvalid during requester 1's DATA phase -> no grant change until requester 1's last beat; grant=0100 one cycle after IDLE.
REQ-039 anreset pulsed low mid-burst -> grant=0 and m_rready=0 immediately; after release with s_arvalid=4'b0001, the transaction starts cleanly.
